trig_capture: RTL and testbench
===============================

# trig_capture

Oscilloscope capture controller downstream of the SPI register file. Takes ADC samples and applies decimation and an edge trigger with pre-trigger depth. Writes one capture frame into a circular capture RAM. Configuration comes from the SPI-written registers; the status word goes back into the SPI read map.

## Interface
Parameters:
- DATA_W, 8, ADC sample width
- ADDR_W, 10, capture RAM address width; DEPTH = 2**ADDR_W; ADDR_W <= 14

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous and active-high
- adc_data  in  DATA_W  ADC sample, qualified by adc_valid
- adc_valid  in  1  sample strobe, at most one per clk
- cfg_arm  in  1  single-cycle pulse; starts (or restarts) a capture
- cfg_force  in  1  single-cycle pulse; forces a trigger while waiting
- cfg_edge  in  1  0 = rising, 1 = falling
- cfg_level  in  DATA_W  trigger threshold, unsigned
- cfg_pretrig  in  ADDR_W  samples kept before trigger
- cfg_decim  in  16  keep 1 of (cfg_decim+1) valid samples
- wr_en  out  1  capture RAM write strobe
- wr_addr  out  ADDR_W  capture RAM write address
- wr_data  out  DATA_W  capture RAM write data
- trig_addr  out  ADDR_W  RAM address holding the trigger sample
- busy  out  1  capture in progress
- done  out  1  frame complete; held until next arm or rst
- status  out  16  bit15 = done, bit14 = busy, bit13 = waiting for trigger, bits ADDR_W-1:0 = trig_addr, all other bits 0

## Operation
- All cfg_* except pulses are latched on cfg_arm. They are ignored at all other times.
- Effective pretrig P = min(cfg_pretrig, DEPTH-1).
- Decimation counter: reloads to cfg_decim on arm. On each adc_valid it decrements; a sample is *accepted* when the counter is 0, and the counter then reloads. cfg_decim = 0 means every valid sample is accepted.
- Write pointer reset to 0 on arm, +1 per accepted sample, wraps DEPTH-1 -> 0.
- States:
  - IDLE: busy = 0. cfg_arm goes to PRE (or to WAIT if P = 0).
  - PRE: write accepted samples without trigger check. After P samples, go to WAIT.
  - WAIT: write accepted samples circularly. The trigger is evaluated on each accepted sample, comparing it with the previous accepted sample.
    - Rising edge: prev < level and cur >= level.
    - Falling edge: prev > level and cur <= level.
    - No trigger on the first accepted sample after arm, because no prev exists.
    - A cfg_force pulse sets a pending flag; the next accepted sample triggers unconditionally.
    - On trigger, that sample is written and its address is latched into trig_addr. Go to POST, with remaining count R = DEPTH - P - 1.
  - POST: write R further accepted samples, then go to DONE. If R = 0, go to DONE immediately after the trigger write.
  - DONE: busy = 0, done = 1, no writes. Only cfg_arm leaves DONE.
- cfg_arm in any state aborts the current frame and restarts it. cfg_arm also clears done and trig_addr.
- cfg_force outside WAIT is ignored, and the pending flag is cleared on arm. cfg_force and cfg_arm in the same cycle: arm wins and force is dropped.
- rst mid-capture: everything returns to reset values; no further writes.
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, trig_addr = 0, busy = 0, done = 0, status = 0, state IDLE.

## Timing
- Latency is 1 clk. A sample accepted at edge n produces wr_en = 1 with its addr/data during cycle n+1. wr_en is a single-cycle pulse per accepted sample.
- busy rises the cycle after cfg_arm.
- done rises in the cycle after the final wr_en pulse, and busy falls in the same cycle.
- The trigger decision is combinational on adc_data in the accept cycle; the state change is registered at that edge. trig_addr is valid in the same cycle as the trigger sample's wr_en.
- An adc_valid coincident with cfg_arm is discarded.
- No backpressure: the RAM accepts a write every cycle.

## Structure
- Package scope_pkg holds:
  - the state typedef: enum IDLE/PRE/WAIT/POST/DONE;
  - the status bit-position constants;
  - the edge encodings EDGE_RISE = 0, EDGE_FALL = 1.
- The status bit positions are shared with the SPI read map.
- One sub-module, trig_detect, is natural. It holds the prev-sample register, prev-valid flag and edge/level compare, and outputs a combinational hit.
- The capture RAM is external, instantiated at top level.

## Test plan
All scenarios use ADDR_W = 4 (DEPTH = 16).
- Rising trigger: decim 0, P = 4, level 0x80, ramp 0x70, 0x74, … step 4. Required: trigger on sample 0x80. trig_addr = (trigger index) mod 16. Exactly 16 wr_en pulses total. done one cycle after the 16th pulse.
- Falling edge plus first-sample rule: edge = 1, level 0x40, first sample 0x30, then 0x50 and 0x3C. Required: no trigger on 0x30; trigger on 0x3C. Exactly 11 wr_en pulses after the trigger (P = 4).
- Decimation: cfg_decim = 2, adc_valid every cycle. Required: wr_en every 3rd valid. wr_data equals samples 2, 5, 8, …, counted from the first valid after arm.
- Force: P = 0, constant input 0x10, level 0x80, cfg_force in WAIT. Required: the next accepted sample triggers with trig_addr = 0 plus the samples already written (mod 16). 15 more writes follow, then done.
- Clamp and re-arm: cfg_pretrig = 15, giving R = 0. Required: done directly after the trigger write. A new arm mid-POST clears done, trig_addr and wr_addr to 0 and restarts.
- Reset mid-WAIT: assert rst for 1 cycle. Required: all outputs 0 on the next cycle; no wr_en until a new cfg_arm.

Source files
------------

// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scope_pkg
// Description : Shared types and constants for the scope capture path.
//               Capture FSM state type, status-word bit positions (also
//               used by the SPI read map) and trigger edge encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    // Status word bit positions
    localparam int c_STAT_DONE = 15;
    localparam int c_STAT_BUSY = 14;
    localparam int c_STAT_WAIT = 13;

    // Trigger edge select encodings
    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/trig_detect.sv
`default_nettype none
// ============================================================================
// Module      : trig_detect
// Description : Edge/level trigger comparator. Remembers the previous
//               accepted sample and flags a threshold crossing between it
//               and the current sample.
//   clk, rst      : clock, synchronous active-high reset
//   i_clr         : arm pulse; forgets the previous sample
//   i_accept      : current sample is accepted (becomes the new previous)
//   i_edge_sel    : EDGE_RISE / EDGE_FALL
//   i_sample      : current sample
//   i_level       : unsigned threshold
//   o_hit         : combinational crossing flag for the current sample
// Revision    : 1.0 - initial release
// ============================================================================
module trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_accept,
    input  logic              i_edge_sel,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_level,
    output logic              o_hit
);

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (i_clr) begin
            // Stale sample from the previous frame must never form an edge.
            r_prev_vld <= 1'b0;
        end else if (i_accept) begin
            r_prev     <= i_sample;
            r_prev_vld <= 1'b1;
        end
    end

    always_comb begin
        o_hit = 1'b0;
        if (r_prev_vld) begin
            if (i_edge_sel == EDGE_FALL) begin
                o_hit = (r_prev > i_level) && (i_sample <= i_level);
            end else if (i_edge_sel == EDGE_RISE) begin
                o_hit = (r_prev < i_level) && (i_sample >= i_level);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trig_capture.sv
`default_nettype none
// ============================================================================
// Module      : trig_capture
// Description : Oscilloscope capture controller. Decimates ADC samples,
//               waits for an edge (or forced) trigger after a pre-trigger
//               fill, and writes one frame into an external circular RAM.
//   clk, rst             : clock, synchronous active-high reset
//   adc_data/adc_valid   : sample stream
//   cfg_arm/cfg_force    : single-cycle control pulses
//   cfg_edge/level/pretrig/decim : configuration, latched on cfg_arm
//   wr_en/wr_addr/wr_data: capture RAM write port (1 clk latency)
//   trig_addr            : RAM address of the trigger sample
//   busy/done/status     : progress flags and SPI status word
// Revision    : 1.0 - initial release
// ============================================================================
module trig_capture
    import scope_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              cfg_arm,
    input  logic              cfg_force,
    input  logic              cfg_edge,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic [ADDR_W-1:0] cfg_pretrig,
    input  logic [15:0]       cfg_decim,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done,
    output logic [15:0]       status
);

    localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_MAX = {ADDR_W{1'b1}};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_pre, r_wptr, r_wr_addr, r_trig_addr;
    logic [DATA_W-1:0] r_level, r_wr_data;
    logic [15:0]       r_decim, r_dcnt;
    logic              r_edge, r_pend, r_busy, r_done, r_wr_en;
    logic [ADDR_W-1:0] w_pretrig;
    logic              w_capturing, w_accept, w_hit, w_trigger;

    // An ADDR_W-bit pretrig can never exceed DEPTH-1, so the clamp is free.
    assign w_pretrig   = cfg_pretrig;

    assign w_capturing = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);
    // A sample coincident with arm belongs to no frame and is dropped.
    assign w_accept    = adc_valid && !cfg_arm && w_capturing && (r_dcnt == 16'd0);
    assign w_trigger   = w_accept && (r_state == WAIT) && (r_pend || w_hit);

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (cfg_arm),
        .i_accept   (w_accept),
        .i_edge_sel (r_edge),
        .i_sample   (adc_data),
        .i_level    (r_level),
        .o_hit      (w_hit)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt counts remaining pre-trigger samples in PRE and remaining
    // post-trigger samples in POST.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (cfg_arm) begin
            w_cnt_nxt   = w_pretrig;
            w_state_nxt = (w_pretrig == '0) ? WAIT : PRE;
        end else if (w_accept) begin
            unique case (r_state)
                PRE: begin
                    w_cnt_nxt = r_cnt - c_ONE;
                    if (r_cnt == c_ONE) w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (w_trigger) begin
                        // DEPTH - P - 1 equals the bitwise inverse of P.
                        w_cnt_nxt   = ~r_pre;
                        w_state_nxt = (r_pre == c_MAX) ? DONE : POST;
                    end
                end
                POST: begin
                    w_cnt_nxt = r_cnt - c_ONE;
                    if (r_cnt == c_ONE) w_state_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge      <= 1'b0;
            r_level     <= '0;
            r_decim     <= '0;
            r_pre       <= '0;
            r_dcnt      <= '0;
            r_wptr      <= '0;
            r_pend      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_trig_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (cfg_arm) begin
            r_edge      <= cfg_edge;
            r_level     <= cfg_level;
            r_decim     <= cfg_decim;
            r_pre       <= w_pretrig;
            r_dcnt      <= cfg_decim;
            r_wptr      <= '0;
            r_pend      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_trig_addr <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (adc_valid && w_capturing) begin
                r_dcnt <= (r_dcnt == 16'd0) ? r_decim : (r_dcnt - 16'd1);
            end
            if (w_accept) begin
                r_wr_addr <= r_wptr;
                r_wr_data <= adc_data;
                r_wptr    <= r_wptr + c_ONE;
            end
            if (w_trigger) begin
                r_trig_addr <= r_wptr;
                r_pend      <= 1'b0;
            end else if (cfg_force && (r_state == WAIT)) begin
                r_pend <= 1'b1;
            end
            // State enters DONE with the final write still pending on the
            // RAM port; flags change one cycle later, after that write.
            if (r_state == DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign busy      = r_busy;
    assign done      = r_done;

    // Flags are written last so they take precedence at ADDR_W = 14.
    always_comb begin
        status               = '0;
        status[ADDR_W-1:0]   = r_trig_addr;
        status[c_STAT_DONE]  = r_done;
        status[c_STAT_BUSY]  = r_busy;
        status[c_STAT_WAIT]  = (r_state == WAIT);
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_capture
// Description : Self-checking bench for trig_capture (ADDR_W = 4). A
//               sample-counting reference model predicts every output each
//               cycle; directed tables and sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_capture;

    localparam int DEPTH = 16;

    logic        clk, rst;
    logic [7:0]  adc_data, cfg_level;
    logic        adc_valid, cfg_arm, cfg_force, cfg_edge;
    logic [3:0]  cfg_pretrig;
    logic [15:0] cfg_decim;
    logic        wr_en, busy, done;
    logic [3:0]  wr_addr, trig_addr;
    logic [7:0]  wr_data;
    logic [15:0] status;

    trig_capture #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .cfg_arm(cfg_arm), .cfg_force(cfg_force), .cfg_edge(cfg_edge),
        .cfg_level(cfg_level), .cfg_pretrig(cfg_pretrig), .cfg_decim(cfg_decim),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
        .busy(busy), .done(done), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // ---------------- reference model ----------------
    // Frame described by counts: valid samples seen, samples accepted,
    // index of the trigger sample. A frame holds DEPTH-P samples from the
    // trigger onward.
    bit         m_cap = 0, m_fin = 0, m_pend = 0, m_trigd = 0;
    int         m_nacc = 0, m_nval = 0, m_tidx = 0, m_P = 0;
    logic [7:0] m_prev = 0, m_level = 0;
    logic [15:0] m_decim = 0;
    logic       m_edge = 0;
    logic       e_wr_en = 0, e_busy = 0, e_done = 0, e_wait = 0;
    logic [3:0] e_wr_addr = 0, e_trig = 0;
    logic [7:0] e_wr_data = 0;

    task automatic model_step();
        bit waiting, acc, hit;
        int p;
        waiting = m_cap && (m_nacc >= m_P) && !m_trigd;
        hit     = 0;
        e_wr_en = 0;
        if (rst) begin
            m_cap = 0; m_fin = 0; m_pend = 0; m_trigd = 0;
            e_wr_addr = 0; e_wr_data = 0; e_trig = 0; e_busy = 0; e_done = 0;
        end else if (cfg_arm) begin
            m_cap = 1; m_fin = 0; m_pend = 0; m_trigd = 0; m_nacc = 0; m_nval = 0;
            p = int'(cfg_pretrig);
            m_P = (p < DEPTH - 1) ? p : DEPTH - 1;
            m_decim = cfg_decim; m_edge = cfg_edge; m_level = cfg_level;
            e_wr_addr = 0; e_trig = 0; e_done = 0; e_busy = 1;
        end else begin
            if (m_fin) begin e_done = 1; e_busy = 0; m_fin = 0; end
            if (m_cap && adc_valid) begin
                acc = ((m_nval % (int'(m_decim) + 1)) == int'(m_decim));
                m_nval++;
                if (acc) begin
                    if (waiting)
                        hit = m_pend || ((m_nacc > 0) &&
                              (m_edge ? (m_prev > m_level && adc_data <= m_level)
                                      : (m_prev < m_level && adc_data >= m_level)));
                    e_wr_en = 1; e_wr_addr = 4'(m_nacc % DEPTH); e_wr_data = adc_data;
                    if (hit) begin m_trigd = 1; m_tidx = m_nacc; e_trig = 4'(m_nacc % DEPTH); end
                    m_prev = adc_data;
                    m_nacc++;
                    if (m_trigd && (m_nacc == m_tidx + DEPTH - m_P)) begin m_cap = 0; m_fin = 1; end
                end
            end
            if (hit) m_pend = 0;
            else if (cfg_force && waiting) m_pend = 1;
        end
        e_wait = m_cap && (m_nacc >= m_P) && !m_trigd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
        chk("wr_data", 32'(wr_data), 32'(e_wr_data));
        chk("trig_addr", 32'(trig_addr), 32'(e_trig));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("status", 32'(status), 32'({e_done, e_busy, e_wait, 9'b0, e_trig}));
    endtask

    // Inputs change at the falling edge; outputs are checked there too.
    task automatic step(input logic a, input logic f, input logic v, input logic [7:0] d);
        cfg_arm = a; cfg_force = f; adc_valid = v; adc_data = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_done(input logic [7:0] fill, output int pulses,
                                  output bit ok, output bit adj);
        bit prev_wr;
        pulses = 0; ok = 0; adj = 0; prev_wr = 0;
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 1, fill);
            if (wr_en) pulses++;
            if (done) begin ok = 1; adj = prev_wr; break; end
            prev_wr = wr_en;
        end
    endtask

    task automatic set_cfg(input logic e, input logic [7:0] lvl,
                           input logic [3:0] pre, input logic [15:0] dec);
        cfg_edge = e; cfg_level = lvl; cfg_pretrig = pre; cfg_decim = dec;
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       ewr;
        logic [3:0] eaddr;
        logic [3:0] etrig;
        logic       ewait;
    } vec_t;

    vec_t fall_tbl[5];

    initial begin
        int  pulses, last_i, done_i;
        bit  ok, adj;
        logic [7:0] d;
        logic [7:0] dq[$];
        logic [7:0] seq4[5];

        fall_tbl[0] = '{1'b1, 8'h30, 1'b1, 4'd0, 4'd0, 1'b1};
        fall_tbl[1] = '{1'b1, 8'h50, 1'b1, 4'd1, 4'd0, 1'b1};
        fall_tbl[2] = '{1'b0, 8'h00, 1'b0, 4'd1, 4'd0, 1'b1};
        fall_tbl[3] = '{1'b1, 8'h3C, 1'b1, 4'd2, 4'd2, 1'b0};
        fall_tbl[4] = '{1'b1, 8'h3C, 1'b1, 4'd3, 4'd2, 1'b0};
        seq4[0] = 8'h30; seq4[1] = 8'h50; seq4[2] = 8'h3C; seq4[3] = 8'h50; seq4[4] = 8'h3C;

        rst = 1; set_cfg(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 8'h55);
        chk("reset_status", 32'(status), 32'h0);
        chk("reset_wr_en", 32'(wr_en), 32'h0);
        rst = 0;

        // Rising ramp, P = 4
        set_cfg(0, 8'h80, 4'd4, 16'd0);
        step(1, 0, 0, 0);
        chk("arm_busy", 32'(busy), 32'h1);
        pulses = 0; last_i = -1; done_i = -1;
        for (int i = 0; i < 40; i++) begin
            d = 8'h70 + 8'(4 * i);
            step(0, 0, 1, d);
            if (wr_en) begin pulses++; last_i = i; end
            if (done) begin done_i = i; break; end
        end
        chk("ramp_pulses", 32'(pulses), 32'd16);
        chk("ramp_trig_addr", 32'(trig_addr), 32'd4);
        chk("ramp_done_lat", 32'(done_i - last_i), 32'd1);

        // Falling edge, P = 0: stale prev (0xAC) must not trigger on 0x30
        set_cfg(1, 8'h40, 4'd0, 16'd0);
        step(1, 0, 0, 0);
        for (int r = 0; r < 5; r++) begin
            step(0, 0, fall_tbl[r].valid, fall_tbl[r].data);
            chk("fall_tbl_wr_en", 32'(wr_en), 32'(fall_tbl[r].ewr));
            chk("fall_tbl_wr_addr", 32'(wr_addr), 32'(fall_tbl[r].eaddr));
            chk("fall_tbl_trig", 32'(trig_addr), 32'(fall_tbl[r].etrig));
            chk("fall_tbl_wait", 32'(status[13]), 32'(fall_tbl[r].ewait));
        end

        // Falling edge, P = 4: 11 writes after the trigger
        set_cfg(1, 8'h40, 4'd4, 16'd0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, seq4[i]);
        chk("fall4_trig_addr", 32'(trig_addr), 32'd4);
        run_until_done(8'h20, pulses, ok, adj);
        chk("fall4_done", 32'(ok), 32'd1);
        chk("fall4_post_pulses", 32'(pulses), 32'd11);

        // Decimation by 3
        set_cfg(0, 8'hFF, 4'd4, 16'd2);
        step(1, 0, 0, 0);
        dq.delete();
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 1, 8'(k));
            if (wr_en) dq.push_back(wr_data);
        end
        chk("decim_count", 32'(dq.size()), 32'd4);
        for (int j = 0; j < dq.size(); j++) chk("decim_data", 32'(dq[j]), 32'(3 * j + 2));

        // Force trigger, P = 0
        set_cfg(0, 8'h80, 4'd0, 16'd0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h10);
        step(0, 1, 0, 0);
        step(0, 0, 1, 8'h10);
        chk("force_trig_addr", 32'(trig_addr), 32'd3);
        run_until_done(8'h10, pulses, ok, adj);
        chk("force_done", 32'(ok), 32'd1);
        chk("force_post_pulses", 32'(pulses), 32'd15);

        // Pretrig 15: R = 0, done right after the trigger write
        set_cfg(0, 8'h80, 4'd15, 16'd0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 8'h10);
        step(0, 1, 0, 0);
        step(0, 0, 1, 8'h10);
        chk("clamp_trig_wr", 32'(wr_en), 32'd1);
        chk("clamp_trig_addr", 32'(trig_addr), 32'd15);
        step(0, 0, 1, 8'h10);
        chk("clamp_done", 32'(done), 32'd1);
        chk("clamp_busy", 32'(busy), 32'd0);

        // Re-arm mid-POST, with a coincident (discarded) sample
        set_cfg(0, 8'h80, 4'd4, 16'd0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h10);
        step(0, 1, 0, 0);
        step(0, 0, 1, 8'h10);
        step(0, 0, 1, 8'h11);
        step(0, 0, 1, 8'h12);
        step(1, 0, 1, 8'h99);
        chk("rearm_wr_en", 32'(wr_en), 32'd0);
        chk("rearm_wr_addr", 32'(wr_addr), 32'd0);
        chk("rearm_trig", 32'(trig_addr), 32'd0);
        chk("rearm_done", 32'(done), 32'd0);
        step(0, 0, 1, 8'h21);
        chk("rearm_first_data", 32'(wr_data), 32'h21);

        // Reset mid-WAIT
        set_cfg(0, 8'hF0, 4'd0, 16'd0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'h02);
        rst = 1;
        step(0, 0, 1, 8'h55);
        rst = 0;
        chk("rst_status", 32'(status), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 8'(i));
            chk("rst_no_write", 32'(wr_en), 32'h0);
        end

        // Randomized traffic: cfg changes at random times must be ignored
        for (int c = 0; c < 4000; c++) begin
            logic a, f, v;
            if ($urandom_range(9) == 0)
                set_cfg(1'($urandom), 8'($urandom), 4'($urandom), 16'($urandom_range(3)));
            a = ($urandom_range(199) == 0) || (done && $urandom_range(19) == 0);
            f = ($urandom_range(29) == 0);
            v = ($urandom_range(3) != 0);
            rst = ($urandom_range(999) == 0);
            step(a, f, v, 8'($urandom));
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
